// File: rtl/axi_pkg.sv
// Shared AXI4 types for the letc memory subsystem: response codes, burst kinds
// and the widest supported beat size.
package axi_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2
  } burst_e;

  localparam logic [2:0] AXI_MAX_SIZE = 3'd2;

  // A range fault outranks a command fault when both are present.
  function automatic resp_e err_resp(input logic i_dec, input logic i_slv);
    if (i_dec) return RESP_DECERR;
    if (i_slv) return RESP_SLVERR;
    return RESP_OKAY;
  endfunction

endpackage

// File: rtl/letc_axi_sram_mem.sv
// Single-port word memory: synchronous read, byte-enable write, one access per cycle.
module letc_axi_sram_mem #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = 10
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic [3:0]        i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (|i_we) begin
        for (int unsigned b = 0; b < 4; b++) begin
          if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/letc_axi_sram.sv
// AXI4 subordinate SRAM, one transaction at a time, INCR/FIXED bursts.
// Optional LETC_AXI_SRAM_STALL_EN adds LFSR-driven backpressure on ready/valid.
module letc_axi_sram
  import axi_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned ID_W        = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [ID_W-1:0] i_awid,
  input  logic [31:0]     i_awaddr,
  input  logic [7:0]      i_awlen,
  input  logic [2:0]      i_awsize,
  input  logic [1:0]      i_awburst,
  input  logic            i_awvalid,
  output logic            o_awready,
  input  logic [31:0]     i_wdata,
  input  logic [3:0]      i_wstrb,
  input  logic            i_wlast,
  input  logic            i_wvalid,
  output logic            o_wready,
  output logic [ID_W-1:0] o_bid,
  output resp_e           o_bresp,
  output logic            o_bvalid,
  input  logic            i_bready,
  input  logic [ID_W-1:0] i_arid,
  input  logic [31:0]     i_araddr,
  input  logic [7:0]      i_arlen,
  input  logic [2:0]      i_arsize,
  input  logic [1:0]      i_arburst,
  input  logic            i_arvalid,
  output logic            o_arready,
  output logic [ID_W-1:0] o_rid,
  output logic [31:0]     o_rdata,
  output resp_e           o_rresp,
  output logic            o_rlast,
  output logic            o_rvalid,
  input  logic            i_rready
);

  localparam int unsigned AW    = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;

  state_e          r_state, w_state_nx;
  logic            r_prefer_read;
  logic [ID_W-1:0] r_id;
  logic [31:0]     r_addr;
  logic [7:0]      r_len, r_beat;
  logic [2:0]      r_size;
  logic [1:0]      r_burst;
  logic            r_err_dec, r_err_slv, r_over;
  logic            r_rvalid, r_rpend;

  logic            w_stall, w_grant_rd, w_grant_wr;
  logic            w_aw_hs, w_ar_hs, w_w_hs, w_r_hs, w_rlast;
  logic            w_fetch, w_wr_en, w_in_range, w_bad_cmd;
  logic [31:0]     w_addr_in, w_addr_nx, w_mem_addr, w_mem_rdata;
  logic [7:0]      w_len_in;
  logic [2:0]      w_size_in;
  logic [1:0]      w_burst_in;

`ifdef LETC_AXI_SRAM_STALL_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_lfsr <= 16'hACE1;
    else       r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_stall = r_lfsr[0];
`else
  assign w_stall = 1'b0;
`endif

  assign w_grant_rd = i_arvalid && (!i_awvalid || r_prefer_read);
  assign w_grant_wr = i_awvalid && !w_grant_rd;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    o_awready  = 1'b0;
    o_arready  = 1'b0;
    o_wready   = 1'b0;
    o_bvalid   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_stall && !i_rst) begin
          if (w_grant_wr) begin
            o_awready  = 1'b1;
            w_state_nx = WDATA;
          end else if (w_grant_rd) begin
            o_arready  = 1'b1;
            w_state_nx = RDATA;
          end
        end
      end
      WDATA: begin
        o_wready = !w_stall;
        if (i_wvalid && !w_stall && i_wlast) w_state_nx = WRESP;
      end
      WRESP: begin
        o_bvalid = 1'b1;
        if (i_bready) w_state_nx = IDLE;
      end
      RDATA: begin
        if (w_r_hs && w_rlast) w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  assign w_aw_hs = o_awready;
  assign w_ar_hs = o_arready;
  assign w_w_hs  = o_wready && i_wvalid;
  assign w_r_hs  = r_rvalid && i_rready;
  assign w_rlast = (r_beat == r_len);

  assign w_addr_in  = w_aw_hs ? i_awaddr  : i_araddr;
  assign w_len_in   = w_aw_hs ? i_awlen   : i_arlen;
  assign w_size_in  = w_aw_hs ? i_awsize  : i_arsize;
  assign w_burst_in = w_aw_hs ? i_awburst : i_arburst;
  assign w_in_range = ({1'b0, w_addr_in} >= {1'b0, BASE_ADDR}) && ({1'b0, w_addr_in} < LIMIT);
  assign w_bad_cmd  = (w_size_in > AXI_MAX_SIZE) ||
                      ((w_burst_in != BURST_FIXED) && (w_burst_in != BURST_INCR));
  assign w_addr_nx  = (r_burst == BURST_INCR) ? r_addr + (32'd1 << r_size) : r_addr;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_prefer_read <= 1'b0;
      r_id          <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_err_dec     <= 1'b0;
      r_err_slv     <= 1'b0;
      r_over        <= 1'b0;
    end else if (w_aw_hs || w_ar_hs) begin
      r_prefer_read <= !r_prefer_read;
      r_id          <= w_aw_hs ? i_awid : i_arid;
      r_addr        <= w_addr_in;
      r_len         <= w_len_in;
      r_size        <= w_size_in;
      r_burst       <= w_burst_in;
      r_beat        <= '0;
      r_err_dec     <= !w_in_range;
      r_err_slv     <= w_bad_cmd;
      r_over        <= 1'b0;
    end else if (w_w_hs) begin
      r_beat <= r_beat + 8'd1;
      r_addr <= w_addr_nx;
      if (i_wlast != w_rlast)     r_err_slv <= 1'b1;
      if (!i_wlast && w_rlast)    r_over    <= 1'b1;
    end else if (w_r_hs) begin
      r_beat <= r_beat + 8'd1;
      r_addr <= w_addr_nx;
    end
  end

  // Fetch the next word only when the current beat is consumed, so rdata holds while stalled.
  assign w_fetch    = w_ar_hs || (w_r_hs && !w_rlast);
  assign w_wr_en    = w_w_hs && !r_err_dec && !r_err_slv && !r_over;
  assign w_mem_addr = (r_state == WDATA) ? r_addr : (w_ar_hs ? i_araddr : w_addr_nx);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rvalid <= 1'b0;
      r_rpend  <= 1'b0;
    end else if (w_fetch) begin
      r_rvalid <= !w_stall;
      r_rpend  <= w_stall;
    end else if (w_r_hs) begin
      r_rvalid <= 1'b0;
    end else if (r_rpend && !w_stall) begin
      r_rvalid <= 1'b1;
      r_rpend  <= 1'b0;
    end
  end

  letc_axi_sram_mem #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (AW)
  ) u_mem (
    .i_clk  (i_clk),
    .i_en   (w_fetch || w_wr_en),
    .i_we   (w_wr_en ? i_wstrb : 4'b0000),
    .i_addr (AW'((w_mem_addr - BASE_ADDR) >> 2)),
    .i_wdata(i_wdata),
    .o_rdata(w_mem_rdata)
  );

  assign o_bid   = r_id;
  assign o_bresp = (r_state == WRESP) ? err_resp(r_err_dec, r_err_slv) : RESP_OKAY;
  assign o_rid   = r_id;
  assign o_rvalid = r_rvalid;
  assign o_rlast = r_rvalid && w_rlast;
  assign o_rresp = r_rvalid ? err_resp(r_err_dec, r_err_slv) : RESP_OKAY;
  assign o_rdata = (r_rvalid && !r_err_dec && !r_err_slv) ? w_mem_rdata : '0;

endmodule
